// File: rtl/key_pulse_gen_pkg.sv
// Shared constants, FSM state encoding and a width helper for the key pulse generator.
package key_pulse_gen_pkg;

  localparam int unsigned DefSampleDiv = 1250000;
  localparam int unsigned DefStableN   = 2;
  localparam int unsigned DefRepeatDly = 20;
  localparam int unsigned DefRepeatPer = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StRpt  = 2'd2
  } key_state_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_chan.sv
// One push-button channel: two-flop synchronizer, tick-sampled debouncer and
// press/auto-repeat FSM with a registered one-cycle press pulse.
module key_chan
  import key_pulse_gen_pkg::*;
#(
  parameter int unsigned STABLE_N   = DefStableN,
  parameter int unsigned REPEAT_DLY = DefRepeatDly,
  parameter int unsigned REPEAT_PER = DefRepeatPer,
  parameter bit          REPEAT_EN  = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic key_i,
  input  logic tick_i,
  output logic press_o,
  output logic level_o
);

  localparam int unsigned SW = cnt_width(STABLE_N);
  localparam int unsigned RW = cnt_width(max_u(REPEAT_DLY, REPEAT_PER));

  logic [1:0]    sync_q;
  logic [SW-1:0] stab_q;
  logic [SW-1:0] stab_inc;
  logic          level_q;
  logic          sample;
  logic          diff;
  logic          toggle;
  logic          rise;
  logic          fall;

  key_state_e    state_q;
  logic [RW-1:0] rpt_q;
  logic          press_q;

  // Raw key is active-low; reset value of all ones means released.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_i};
    end
  end

  assign sample   = ~sync_q[1];
  assign stab_inc = stab_q + 1'b1;
  assign diff     = tick_i && (sample != level_q);
  assign toggle   = diff && (stab_inc == SW'(STABLE_N));
  assign rise     = toggle && !level_q;
  assign fall     = toggle && level_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stab_q  <= '0;
      level_q <= 1'b0;
    end else if (tick_i) begin
      if (toggle) begin
        stab_q  <= '0;
        level_q <= ~level_q;
      end else if (diff) begin
        stab_q  <= stab_inc;
      end else begin
        stab_q  <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      rpt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (fall) begin
        state_q <= StIdle;
        rpt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rise) begin
              state_q <= StHold;
              rpt_q   <= '0;
              press_q <= 1'b1;
            end
          end
          StHold: begin
            if (tick_i) begin
              if (REPEAT_EN && (rpt_q == RW'(REPEAT_DLY - 1))) begin
                state_q <= StRpt;
                rpt_q   <= '0;
                press_q <= 1'b1;
              end else if (rpt_q != RW'(REPEAT_DLY)) begin
                // Saturates so a long hold with repeat disabled never wraps.
                rpt_q <= rpt_q + 1'b1;
              end
            end
          end
          StRpt: begin
            if (tick_i) begin
              if (rpt_q == RW'(REPEAT_PER - 1)) begin
                rpt_q   <= '0;
                press_q <= 1'b1;
              end else begin
                rpt_q <= rpt_q + 1'b1;
              end
            end
          end
          default: begin
            state_q <= StIdle;
            rpt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign press_o = press_q;
  assign level_o = level_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Debounced push-button pulse generator: one shared sample prescaler feeding
// NKEY independent key_chan instances.
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int unsigned          NKEY       = 3,
  parameter int unsigned          SAMPLE_DIV = DefSampleDiv,
  parameter int unsigned          STABLE_N   = DefStableN,
  parameter int unsigned          REPEAT_DLY = DefRepeatDly,
  parameter int unsigned          REPEAT_PER = DefRepeatPer,
  parameter logic [NKEY-1:0]      REPEAT_EN  = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NKEY-1:0] KEY,
  output logic [NKEY-1:0] PRESS,
  output logic [NKEY-1:0] LEVEL
);

  localparam int unsigned     PW     = cnt_width(SAMPLE_DIV - 1);
  localparam logic [PW-1:0]   DivMax = PW'(SAMPLE_DIV - 1);

  logic [PW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == DivMax);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  for (genvar i = 0; i < int'(NKEY); i++) begin : g_chan
    key_chan #(
      .STABLE_N  (STABLE_N),
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER),
      .REPEAT_EN (REPEAT_EN[i])
    ) u_chan (
      .CLK    (CLK),
      .RST    (RST),
      .key_i  (KEY[i]),
      .tick_i (tick),
      .press_o(PRESS[i]),
      .level_o(LEVEL[i])
    );
  end

endmodule

// File: doc/key_pulse_gen.md
KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 SHALL have parameter NKEY, default 3; number of push-button channels.
REQ-002 SHALL have parameter SAMPLE_DIV, default 1250000; clock cycles per sample tick (25 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE_N, default 2; consecutive opposite samples needed to flip the debounced state.
REQ-004 SHALL have parameter REPEAT_DLY, default 20; sample ticks from press pulse to first repeat pulse.
REQ-005 SHALL have parameter REPEAT_PER, default 4; sample ticks between repeat pulses.
REQ-006 SHALL have parameter REPEAT_EN, default all-zero, NKEY bits; per-channel auto-repeat enable.
REQ-007 SHALL have port CLK, input, 1 bit; the single clock; all state on rising edge.
REQ-008 SHALL have port RST, input, 1 bit; asynchronous, active-low reset.
REQ-009 SHALL have port KEY, input, NKEY bits; raw board buttons, asynchronous, active-low (0 = pressed).
REQ-010 SHALL have port PRESS, output, NKEY bits; one-cycle active-high pulse per press or repeat event.
REQ-011 SHALL have port LEVEL, output, NKEY bits; debounced pressed state, active-high.

Function
REQ-012 SHALL pass each KEY bit through a two-flop synchronizer and invert it, giving sampled pressed = 1.
REQ-013 SHALL run one shared prescaler counting 0..SAMPLE_DIV-1 and wrapping to 0; TICK is high for exactly the one cycle in which the count equals SAMPLE_DIV-1.
REQ-014 SHALL update per-channel state only in TICK cycles.
REQ-015 In a TICK cycle, a synchronized sample different from LEVEL SHALL increment the stability count; a sample equal to LEVEL SHALL clear it.
REQ-016 When the stability count reaches STABLE_N, LEVEL SHALL toggle at that clock edge and the count SHALL clear.
REQ-017 PRESS SHALL pulse high for one cycle at the same edge where LEVEL goes 0->1; a 1->0 transition produces no pulse.
REQ-018 The per-channel FSM SHALL have three states:
  - IDLE: LEVEL=0.
  - HOLD: LEVEL=1, counting REPEAT_DLY ticks.
  - RPT: LEVEL=1, counting REPEAT_PER ticks.
REQ-019 The FSM SHALL transition as follows:
  - IDLE->HOLD on rise.
  - HOLD->RPT after REPEAT_DLY ticks, with a PRESS pulse, only if REPEAT_EN[i]=1.
  - RPT emits a PRESS pulse every REPEAT_PER ticks.
  - Any state->IDLE on LEVEL fall, which clears the repeat counter.
REQ-020 With REPEAT_EN[i]=0, a channel SHALL remain in HOLD until release and emit exactly one PRESS per debounced press.
REQ-021 Channels SHALL be fully independent, and simultaneous presses SHALL produce simultaneous PRESS bits.
REQ-022 Repeat counters SHALL saturate and never wrap while in HOLD with repeat disabled.
REQ-023 Bounce shorter than STABLE_N ticks SHALL change neither LEVEL nor PRESS.

Reset
REQ-024 When RST=0, all flops SHALL clear asynchronously: synchronizers to released, prescaler 0, counts 0, FSM IDLE, PRESS=0, LEVEL=0.
REQ-025 A key held through reset release SHALL produce one PRESS after STABLE_N ticks.
REQ-026 A reset asserted mid-hold or mid-repeat SHALL abort the sequence with no further PRESS pulse until a new debounced press occurs.

Structure
REQ-027 A shared package/include SHALL hold:
  - the default SAMPLE_DIV, STABLE_N, REPEAT_DLY and REPEAT_PER constants;
  - the FSM state encodings IDLE/HOLD/RPT.
REQ-028 The design SHALL contain one shared prescaler plus the sub-module key_chan (synchronizer, debouncer, FSM) instantiated NKEY times.

Verification (SAMPLE_DIV=4, STABLE_N=2, REPEAT_DLY=5, REPEAT_PER=2, NKEY=3, REPEAT_EN=3'b011)
REQ-029 Clean press: KEY[0] low for 40 cycles -> exactly one PRESS[0] pulse 2 ticks after sync; LEVEL[0]=1 until 2 ticks after release.
REQ-030 Bounce: KEY[1] toggled every 3 cycles for 20 cycles, then released -> no PRESS[1], LEVEL[1] stays 0.
REQ-031 Auto-repeat: KEY[0] held for 60 cycles -> PRESS[0] at the debounce edge, then 5 ticks later, then every 2 ticks until release.
REQ-032 Repeat disabled: KEY[2] held for 60 cycles -> exactly one PRESS[2]; LEVEL[2] stays high for the whole hold.
REQ-033 Simultaneous press: KEY=3'b000 in one cycle -> PRESS=3'b111 pulsed in a single cycle.
REQ-034 Reset mid-repeat: RST low for 2 cycles during RPT with the key still held -> outputs go 0 immediately; one fresh PRESS follows 2 ticks after RST rises.
